// File: rtl/c2c_rd_arbiter_if.sv
// c2c_rd_arbiter_if
// Bundles the two core read ports (instruction fetch, load) and the shared
// memory read port of the 2:1 read arbiter.
//   i_re/i_addr -> i_ack/i_data : instruction requester handshake
//   d_re/d_addr -> d_ack/d_data : data requester handshake
//   m_re/m_addr <- m_ack/m_data : shared memory read port
//   timeout                     : pulse on a watchdog-forced completion
// Modports:
//   master : environment side (requesters + memory) that drives requests and
//            memory responses.
//   slave  : the arbiter itself.
interface c2c_rd_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_re;
  logic [XLEN-1:0] i_addr;
  logic            i_ack;
  logic [XLEN-1:0] i_data;
  logic            d_re;
  logic [XLEN-1:0] d_addr;
  logic            d_ack;
  logic [XLEN-1:0] d_data;
  logic            m_re;
  logic [XLEN-1:0] m_addr;
  logic            m_ack;
  logic [XLEN-1:0] m_data;
  logic            timeout;

  modport master (
    output i_re, i_addr, d_re, d_addr, m_ack, m_data,
    input  i_ack, i_data, d_ack, d_data, m_re, m_addr, timeout
  );

  modport slave (
    input  i_re, i_addr, d_re, d_addr, m_ack, m_data,
    output i_ack, i_data, d_ack, d_data, m_re, m_addr, timeout
  );
endinterface

// File: rtl/c2c_rd_arbiter.sv
// c2c_rd_arbiter
// Two-to-one read arbiter sharing one memory read port between the core's
// instruction-fetch and load read ports. One transaction is granted at a
// time; the granted address is registered, the memory response is routed
// back to the winner with zero added latency, and a watchdog forces
// completion (ack with zero data plus a timeout pulse) after TIMEOUT grant
// cycles without m_ack (TIMEOUT = 0 disables the watchdog).
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : c2c_rd_arbiter_if.slave (requester and memory handshakes)
// Parameters: XLEN (address/data width), TIMEOUT (watchdog limit).
// Optional feature: define C2C_RR_ARB_EN for round-robin priority in IDLE
// (a last-served bit favours the other requester); otherwise data has fixed
// priority over instruction.
module c2c_rd_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             reset_n,
  c2c_rd_arbiter_if.slave bus
);

  // Counter is sized to hold TIMEOUT; keep at least one bit when disabled.
  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            WD_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0] WD_LAST = WD_EN ? CW'(TIMEOUT - 1) : {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [XLEN-1:0] addr_r;
  logic [CW-1:0]   cnt_r;

  logic            load_d_s;
  logic            load_i_s;
  logic            wd_hit_s;
  logic            done_s;
  logic            forced_s;
  logic            prefer_d_s;
  logic            m_re_s;
  logic [XLEN-1:0] m_addr_s;
  logic            i_ack_s;
  logic [XLEN-1:0] i_data_s;
  logic            d_ack_s;
  logic [XLEN-1:0] d_data_s;
  logic            timeout_s;

`ifdef C2C_RR_ARB_EN
  // 1 = instruction was served last, so data is favoured next.
  logic last_i_r;

  // Last-served register: flips to the requester completed this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_i_r <= 1'b1;
    end else if (done_s && (state_r == GRANT_D)) begin
      last_i_r <= 1'b0;
    end else if (done_s && (state_r == GRANT_I)) begin
      last_i_r <= 1'b1;
    end else begin
      last_i_r <= last_i_r;
    end
  end

  // Round-robin tie-break in IDLE.
  always_comb begin
    prefer_d_s = last_i_r;
  end
`else
  // Fixed tie-break in IDLE: data before instruction.
  always_comb begin
    prefer_d_s = 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, grant handoff and combinational ack routing.
  always_comb begin
    state_s   = state_r;
    load_d_s  = 1'b0;
    load_i_s  = 1'b0;
    m_re_s    = 1'b0;
    m_addr_s  = {XLEN{1'b0}};
    i_ack_s   = 1'b0;
    i_data_s  = {XLEN{1'b0}};
    d_ack_s   = 1'b0;
    d_data_s  = {XLEN{1'b0}};
    timeout_s = 1'b0;
    wd_hit_s  = WD_EN && (cnt_r == WD_LAST);
    done_s    = bus.m_ack || wd_hit_s;
    // A real memory ack on the last watchdog cycle wins over the timeout.
    forced_s  = !bus.m_ack && wd_hit_s;

    case (state_r)
      IDLE: begin
        if (bus.d_re && (!bus.i_re || prefer_d_s)) begin
          state_s  = GRANT_D;
          load_d_s = 1'b1;
        end else if (bus.i_re) begin
          state_s  = GRANT_I;
          load_i_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_D: begin
        m_re_s   = 1'b1;
        m_addr_s = addr_r;
        if (done_s) begin
          d_ack_s   = 1'b1;
          d_data_s  = forced_s ? {XLEN{1'b0}} : bus.m_data;
          timeout_s = forced_s;
          // d_re is stale here; only the other side can take the next grant.
          if (bus.i_re) begin
            state_s  = GRANT_I;
            load_i_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = GRANT_D;
        end
      end
      GRANT_I: begin
        m_re_s   = 1'b1;
        m_addr_s = addr_r;
        if (done_s) begin
          i_ack_s   = 1'b1;
          i_data_s  = forced_s ? {XLEN{1'b0}} : bus.m_data;
          timeout_s = forced_s;
          if (bus.d_re) begin
            state_s  = GRANT_D;
            load_d_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = GRANT_I;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Granted address latch; loaded only when a grant is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r <= {XLEN{1'b0}};
    end else if (load_d_s) begin
      addr_r <= bus.d_addr;
    end else if (load_i_s) begin
      addr_r <= bus.i_addr;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Watchdog counter: zero in IDLE and after every completion (so a handoff
  // starts the next grant at 0), saturating while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == IDLE) || done_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.m_re    = m_re_s;
  assign bus.m_addr  = m_addr_s;
  assign bus.i_ack   = i_ack_s;
  assign bus.i_data  = i_data_s;
  assign bus.d_ack   = d_ack_s;
  assign bus.d_data  = d_data_s;
  assign bus.timeout = timeout_s;

endmodule

// File: tb/tb_c2c_rd_arbiter.sv
// tb_c2c_rd_arbiter
// Drives two arbiter instances (TIMEOUT=255 and TIMEOUT=4) with identical
// stimulus. Each cycle both are compared against a transaction-level model;
// directed scenarios additionally check fixed expected values.
module tb_c2c_rd_arbiter;
  localparam int XLEN = 32;
  localparam int TO_A = 255;
  localparam int TO_W = 4;
  localparam int OWN_NONE = 0;
  localparam int OWN_D = 1;
  localparam int OWN_I = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            i_re = 1'b0;
  logic [XLEN-1:0] i_addr = 32'h0;
  logic            d_re = 1'b0;
  logic [XLEN-1:0] d_addr = 32'h0;
  logic            m_ack = 1'b0;
  logic [XLEN-1:0] m_data = 32'h0;

  c2c_rd_arbiter_if #(.XLEN(XLEN)) bus_a ();
  c2c_rd_arbiter_if #(.XLEN(XLEN)) bus_w ();

  assign bus_a.i_re = i_re;   assign bus_w.i_re = i_re;
  assign bus_a.i_addr = i_addr; assign bus_w.i_addr = i_addr;
  assign bus_a.d_re = d_re;   assign bus_w.d_re = d_re;
  assign bus_a.d_addr = d_addr; assign bus_w.d_addr = d_addr;
  assign bus_a.m_ack = m_ack; assign bus_w.m_ack = m_ack;
  assign bus_a.m_data = m_data; assign bus_w.m_data = m_data;

  c2c_rd_arbiter #(.XLEN(XLEN), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
  c2c_rd_arbiter #(.XLEN(XLEN), .TIMEOUT(TO_W)) dut_w (
    .clk(clk), .reset_n(reset_n), .bus(bus_w.slave));

  typedef struct {
    int              owner;
    logic [XLEN-1:0] addr;
    int              cnt;
    bit              last_i;
  } mdl_t;

  typedef struct {
    logic            m_re;
    logic [XLEN-1:0] m_addr;
    logic            i_ack;
    logic [XLEN-1:0] i_data;
    logic            d_ack;
    logic [XLEN-1:0] d_data;
    logic            tmo;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  mdl_t ma, mw;
  exp_t last_ea;

  function automatic mdl_t reset_model();
    mdl_t m;
    m.owner = OWN_NONE; m.addr = 32'h0; m.cnt = 0; m.last_i = 1'b1;
    return m;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.m_re = 1'b0; e.m_addr = 32'h0; e.i_ack = 1'b0; e.i_data = 32'h0;
    e.d_ack = 1'b0; e.d_data = 32'h0; e.tmo = 1'b0;
    return e;
  endfunction

  // Expected outputs for the current cycle, given the model and live inputs.
  function automatic exp_t predict(mdl_t m, int to);
    exp_t e;
    bit   done, forced;
    e = zero_exp();
    if (!reset_n || m.owner == OWN_NONE) return e;
    e.m_re = 1'b1;
    e.m_addr = m.addr;
    done = m_ack || (to != 0 && m.cnt == to - 1);
    forced = done && !m_ack;
    if (done) begin
      if (m.owner == OWN_D) begin
        e.d_ack = 1'b1; e.d_data = forced ? 32'h0 : m_data;
      end else begin
        e.i_ack = 1'b1; e.i_data = forced ? 32'h0 : m_data;
      end
      e.tmo = forced;
    end
    return e;
  endfunction

  // Model update at the clock edge.
  function automatic mdl_t advance(mdl_t m, exp_t e);
    mdl_t n;
    bit   pick_d;
    n = m;
    if (m.owner == OWN_NONE) begin
      n.cnt = 0;
      if (d_re && i_re) begin
`ifdef C2C_RR_ARB_EN
        pick_d = m.last_i;
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = d_re;
      end
      if (pick_d) begin n.owner = OWN_D; n.addr = d_addr; end
      else if (i_re) begin n.owner = OWN_I; n.addr = i_addr; end
    end else if (e.i_ack || e.d_ack) begin
      n.last_i = (m.owner == OWN_I);
      n.cnt = 0;
      if (m.owner == OWN_D && i_re) begin n.owner = OWN_I; n.addr = i_addr; end
      else if (m.owner == OWN_I && d_re) begin n.owner = OWN_D; n.addr = d_addr; end
      else n.owner = OWN_NONE;
    end else begin
      n.cnt = m.cnt + 1;
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [XLEN-1:0] got, logic [XLEN-1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_bus(string p, exp_t e, logic m_re_g, logic [XLEN-1:0] m_addr_g,
                           logic i_ack_g, logic [XLEN-1:0] i_data_g, logic d_ack_g,
                           logic [XLEN-1:0] d_data_g, logic tmo_g);
    chk({p, ".m_re"}, {31'h0, m_re_g}, {31'h0, e.m_re});
    chk({p, ".m_addr"}, m_addr_g, e.m_addr);
    chk({p, ".i_ack"}, {31'h0, i_ack_g}, {31'h0, e.i_ack});
    chk({p, ".i_data"}, i_data_g, e.i_data);
    chk({p, ".d_ack"}, {31'h0, d_ack_g}, {31'h0, e.d_ack});
    chk({p, ".d_data"}, d_data_g, e.d_data);
    chk({p, ".timeout"}, {31'h0, tmo_g}, {31'h0, e.tmo});
  endtask

  // One clock cycle: model check at negedge, model update at posedge.
  task automatic tick();
    exp_t ea, ew;
    @(negedge clk);
    ea = predict(ma, TO_A);
    ew = predict(mw, TO_W);
    check_bus("a", ea, bus_a.m_re, bus_a.m_addr, bus_a.i_ack, bus_a.i_data,
              bus_a.d_ack, bus_a.d_data, bus_a.timeout);
    check_bus("w", ew, bus_w.m_re, bus_w.m_addr, bus_w.i_ack, bus_w.i_data,
              bus_w.d_ack, bus_w.d_data, bus_w.timeout);
    last_ea = ea;
    @(posedge clk);
    if (!reset_n) begin
      ma = reset_model(); mw = reset_model();
    end else begin
      ma = advance(ma, ea); mw = advance(mw, ew);
    end
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic [XLEN-1:0] first_addr, second_addr;
  bit              first_is_d;

  initial begin
    ma = reset_model(); mw = reset_model(); last_ea = zero_exp();

    // Reset state
    tick(); tick();
    chk("rst.m_re", {31'h0, bus_a.m_re}, 32'h0);
    chk("rst.m_addr", bus_a.m_addr, 32'h0);
    reset_n = 1'b1;

    // Single fetch, memory acks 3 cycles after m_re rises
    i_re = 1'b1; i_addr = 32'h100;
    tick();
    settle();
    chk("fetch.m_re", {31'h0, bus_a.m_re}, 32'h1);
    chk("fetch.m_addr", bus_a.m_addr, 32'h100);
    tick(); tick(); tick();
    m_ack = 1'b1; m_data = 32'hDEADBEEF;
    settle();
    chk("fetch.i_ack", {31'h0, bus_a.i_ack}, 32'h1);
    chk("fetch.i_data", bus_a.i_data, 32'hDEADBEEF);
    chk("fetch.d_ack", {31'h0, bus_a.d_ack}, 32'h0);
    tick();
    i_re = 1'b0; m_ack = 1'b0;
    settle();
    chk("fetch.idle", {31'h0, bus_a.m_re}, 32'h0);
    tick();

    // Spurious m_ack in IDLE
    m_ack = 1'b1; m_data = 32'h55;
    settle();
    chk("spur.i_ack", {31'h0, bus_a.i_ack}, 32'h0);
    chk("spur.d_ack", {31'h0, bus_a.d_ack}, 32'h0);
    tick();
    m_ack = 1'b0;
    settle();
    chk("spur.idle", {31'h0, bus_a.m_re}, 32'h0);
    tick();

    // Minimum-length data read: request at t, ack at t+1
    d_re = 1'b1; d_addr = 32'h2000;
    tick();
    m_ack = 1'b1; m_data = 32'h1234;
    settle();
    chk("dmin.d_ack", {31'h0, bus_a.d_ack}, 32'h1);
    chk("dmin.d_data", bus_a.d_data, 32'h1234);
    chk("dmin.m_addr", bus_a.m_addr, 32'h2000);
    tick();
    d_re = 1'b0; m_ack = 1'b0;
    tick();

    // Simultaneous requests; last served is data at this point
`ifdef C2C_RR_ARB_EN
    first_is_d = 1'b0;
`else
    first_is_d = 1'b1;
`endif
    first_addr = first_is_d ? 32'h2000 : 32'h100;
    second_addr = first_is_d ? 32'h100 : 32'h2000;
    i_re = 1'b1; i_addr = 32'h100; d_re = 1'b1; d_addr = 32'h2000;
    tick();
    settle();
    chk("sim.first_addr", bus_a.m_addr, first_addr);
    tick();
    m_ack = 1'b1; m_data = 32'hA5A50001;
    settle();
    chk("sim.first_ack", {31'h0, (first_is_d ? bus_a.d_ack : bus_a.i_ack)}, 32'h1);
    tick();
    if (first_is_d) d_re = 1'b0; else i_re = 1'b0;
    m_ack = 1'b0;
    settle();
    chk("sim.handoff_m_re", {31'h0, bus_a.m_re}, 32'h1);
    chk("sim.handoff_addr", bus_a.m_addr, second_addr);
    tick();
    m_ack = 1'b1; m_data = 32'hA5A50002;
    settle();
    chk("sim.second_ack", {31'h0, (first_is_d ? bus_a.i_ack : bus_a.d_ack)}, 32'h1);
    tick();
    i_re = 1'b0; d_re = 1'b0; m_ack = 1'b0;
    settle();
    chk("sim.idle", {31'h0, bus_a.m_re}, 32'h0);
    tick();

    // Watchdog on the TIMEOUT=4 instance: memory never acks
    d_re = 1'b1; d_addr = 32'h3000;
    tick();
    tick(); tick(); tick();
    settle();
    chk("wd.d_ack", {31'h0, bus_w.d_ack}, 32'h1);
    chk("wd.d_data", bus_w.d_data, 32'h0);
    chk("wd.timeout", {31'h0, bus_w.timeout}, 32'h1);
    chk("wd.no_tmo_long", {31'h0, bus_a.timeout}, 32'h0);
    tick();
    d_re = 1'b0;
    settle();
    chk("wd.m_re_off", {31'h0, bus_w.m_re}, 32'h0);
    m_ack = 1'b1; m_data = 32'h77;
    tick();
    m_ack = 1'b0;
    tick();

    // Reset asserted mid-grant
    i_re = 1'b1; i_addr = 32'h440;
    tick();
    tick();
    reset_n = 1'b0;
    settle();
    chk("rstmid.m_re", {31'h0, bus_a.m_re}, 32'h0);
    chk("rstmid.i_ack", {31'h0, bus_a.i_ack}, 32'h0);
    chk("rstmid.m_addr", bus_a.m_addr, 32'h0);
    tick();
    reset_n = 1'b1;
    settle();
    chk("rstmid.idle", {31'h0, bus_a.m_re}, 32'h0);
    tick();
    settle();
    chk("rstmid.regrant", {31'h0, bus_a.m_re}, 32'h1);
    chk("rstmid.addr", bus_a.m_addr, 32'h440);
    m_ack = 1'b1; m_data = 32'h99;
    tick();
    i_re = 1'b0; m_ack = 1'b0;
    tick();

    // Randomized traffic, requesters follow the long-timeout instance
    for (int k = 0; k < 400; k++) begin
      if (last_ea.i_ack) i_re = 1'b0;
      else if (!i_re && $urandom_range(0, 2) == 0) begin
        i_re = 1'b1; i_addr = $urandom;
      end
      if (last_ea.d_ack) d_re = 1'b0;
      else if (!d_re && $urandom_range(0, 2) == 0) begin
        d_re = 1'b1; d_addr = $urandom;
      end
      m_ack = ($urandom_range(0, 2) == 0);
      m_data = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
